// File: rtl/fpmult_pkg.sv
// Shared types for the fpmult fixed-point multiplier.
package fpmult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/fpmult.sv
// Sequential shift-add fixed-point multiplier with a valid/ready handshake on both sides.
// Optional build macro FPMULT_ROUND_EN: round half up instead of truncating when d > 0.
module fpmult
  import fpmult_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c
);

  localparam int CW  = $clog2(n + 1);
  localparam int RSH = (d > 0) ? d - 1 : 0;
`ifdef FPMULT_ROUND_EN
  localparam logic [2*n-1:0] RND = (d > 0) ? ((2*n)'(1) << RSH) : '0;
`else
  localparam logic [2*n-1:0] RND = '0;
`endif

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*n-1:0] mcand;
  logic [2*n-1:0] acc;
  logic [2*n-1:0] acc_nxt;
  logic [2*n-1:0] term;
  logic [2*n-1:0] prod_rnd;
  logic [n-1:0]   mplier;
  logic           last;
  logic           unused_bits;

  // In two's complement the top multiplier bit carries negative weight, so it is subtracted.
  always_comb begin
    last     = (cnt == CW'(n - 1));
    term     = mplier[0] ? mcand : '0;
    if ((sign != 0) && last) acc_nxt = acc - term;
    else                     acc_nxt = acc + term;
    prod_rnd = acc_nxt + RND;
  end

  assign unused_bits = ^prod_rnd;

  always_comb begin
    state_nxt = state;
    recv_rdy  = (state == IDLE);
    send_val  = (state == DONE);
    case (state)
      IDLE:    if (recv_val) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (send_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: operands are latched once on accept, c only changes on the final CALC edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      c      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (recv_val) begin
            cnt    <= '0;
            acc    <= '0;
            mplier <= b;
            mcand  <= (sign != 0) ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) c <= prod_rnd[n+d-1:d];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult.sv
// Directed scoreboard bench for fpmult (n=32, d=16), one signed and one unsigned instance.
module tb_fpmult;

  localparam int N = 32;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         recv_val_s, recv_val_u, send_rdy;
  logic [N-1:0] a, b;
  logic         recv_rdy_s, send_val_s, recv_rdy_u, send_val_u;
  logic [N-1:0] c_s, c_u;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           latency;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] held;

  fpmult #(.n(N), .d(D), .sign(1)) dut_s (
    .clk(clk), .reset(reset), .recv_val(recv_val_s), .recv_rdy(recv_rdy_s),
    .a(a), .b(b), .send_val(send_val_s), .send_rdy(send_rdy), .c(c_s)
  );

  fpmult #(.n(N), .d(D), .sign(0)) dut_u (
    .clk(clk), .reset(reset), .recv_val(recv_val_u), .recv_rdy(recv_rdy_u),
    .a(a), .b(b), .send_val(send_val_u), .send_rdy(send_rdy), .c(c_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference product from a full-width multiply.
  function automatic logic [N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input bit sgn);
    logic [2*N-1:0] p;
    if (sgn) p = {{N{x[N-1]}}, x} * {{N{y[N-1]}}, y};
    else     p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
`ifdef FPMULT_ROUND_EN
    p = p + ((2*N)'(1) << (D - 1));
`endif
    return p[N+D-1:D];
  endfunction

  // Drives one accepted transaction and returns at the negedge after the accepting edge.
  task automatic applyStimulus(input bit uns, input logic [N-1:0] aa, input logic [N-1:0] bb);
    @(negedge clk);
    a = aa;
    b = bb;
    exp_q.push_back(model(aa, bb, !uns));
    check("recv_rdy_before_accept", N'(uns ? recv_rdy_u : recv_rdy_s), N'(1));
    if (uns) recv_val_u = 1'b1;
    else     recv_val_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    recv_val_s = 1'b0;
    recv_val_u = 1'b0;
  endtask

  task automatic waitResult(input bit uns, input string tag);
    latency = 0;
    while (!(uns ? send_val_u : send_val_s) && latency < 100) begin
      @(posedge clk);
      @(negedge clk);
      latency++;
    end
    check({tag, "_latency"}, N'(latency), N'(32));
  endtask

  task automatic checkOutput(input bit uns, input string tag);
    logic [N-1:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_c"}, uns ? c_u : c_s, exp);
    send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_rdy = 1'b0;
    check({tag, "_send_val_after"}, N'(uns ? send_val_u : send_val_s), N'(0));
    check({tag, "_recv_rdy_after"}, N'(uns ? recv_rdy_u : recv_rdy_s), N'(1));
  endtask

  initial begin
    reset      = 1'b0;
    recv_val_s = 1'b0;
    recv_val_u = 1'b0;
    send_rdy   = 1'b0;
    a          = '0;
    b          = '0;
    #12;
    check("reset_recv_rdy", N'(recv_rdy_s), N'(1));
    check("reset_send_val", N'(send_val_s), N'(0));
    check("reset_c", c_s, '0);
    check("reset_c_u", c_u, '0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] basic signed products");
    applyStimulus(0, 32'h0003_0000, 32'h0002_0000);
    waitResult(0, "three_x_two");
    check("three_x_two_const", c_s, 32'h0006_0000);
    checkOutput(0, "three_x_two");

    applyStimulus(0, 32'hFFFF_8000, 32'h0004_0000);
    check("c_held_in_calc", c_s, 32'h0006_0000);
    waitResult(0, "neg_half_x_four");
    check("neg_half_x_four_const", c_s, 32'hFFFE_0000);
    checkOutput(0, "neg_half_x_four");

    applyStimulus(0, 32'h0000_8000, 32'h0000_8000);
    waitResult(0, "half_sq");
    check("half_sq_const", c_s, 32'h0000_4000);
    checkOutput(0, "half_sq");

    applyStimulus(0, 32'h0000_8000, 32'h0000_0001);
    waitResult(0, "round_edge");
`ifdef FPMULT_ROUND_EN
    check("round_edge_const", c_s, 32'h0000_0001);
`else
    check("round_edge_const", c_s, 32'h0000_0000);
`endif
    checkOutput(0, "round_edge");

    $display("[TB] unsigned wrap");
    applyStimulus(1, 32'hFFFF_0000, 32'h0002_0000);
    waitResult(1, "unsigned_wrap");
    check("unsigned_wrap_const", c_u, 32'hFFFE_0000);
    checkOutput(1, "unsigned_wrap");

    $display("[TB] idle handshake noise");
    @(negedge clk);
    send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_rdy = 1'b0;
    check("idle_send_rdy_state", N'(recv_rdy_s), N'(1));
    check("idle_send_rdy_c", c_u, 32'hFFFE_0000);

    $display("[TB] stall in DONE");
    applyStimulus(0, 32'h0001_8000, 32'h0001_8000);
    waitResult(0, "stall");
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a          = 32'h1234_5678;
        recv_val_s = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      recv_val_s = 1'b0;
      check("stall_send_val", N'(send_val_s), N'(1));
      check("stall_recv_rdy", N'(recv_rdy_s), N'(0));
      check("stall_c", c_s, held);
    end
    check("stall_c_const", c_s, 32'h0002_4000);
    checkOutput(0, "stall");

    $display("[TB] back-to-back with send_rdy held high");
    send_rdy = 1'b1;
    applyStimulus(0, 32'h0001_0000, 32'hFFFF_0000);
    waitResult(0, "b2b_first");
    check("b2b_first_c", c_s, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    check("b2b_pulse_end", N'(send_val_s), N'(0));
    check("b2b_idle", N'(recv_rdy_s), N'(1));
    a          = 32'h0002_8000;
    b          = 32'hFFFE_0000;
    exp_q.push_back(model(a, b, 1'b1));
    recv_val_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    recv_val_s = 1'b0;
    check("b2b_accepted", N'(recv_rdy_s), N'(0));
    waitResult(0, "b2b_second");
    check("b2b_second_c", c_s, exp_q.pop_front());
    check("b2b_second_const", c_s, 32'hFFFB_0000);
    @(posedge clk);
    @(negedge clk);
    send_rdy = 1'b0;
    check("b2b_second_idle", N'(recv_rdy_s), N'(1));

    $display("[TB] reset during CALC");
    applyStimulus(0, 32'h0005_0000, 32'h0003_0000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("abort_recv_rdy", N'(recv_rdy_s), N'(1));
    check("abort_send_val", N'(send_val_s), N'(0));
    check("abort_c", c_s, '0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 32'h0005_0000, 32'h0003_0000);
    waitResult(0, "after_abort");
    check("after_abort_const", c_s, 32'h000F_0000);
    checkOutput(0, "after_abort");

    $display("[TB] random operands");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], $urandom, $urandom);
      waitResult(i[0], "random");
      checkOutput(i[0], "random");
    end

    check("scoreboard_empty", N'(exp_q.size()), N'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
